alu_ctl_sequencer: RTL
======================

// Module: alu_ctl_sequencer
// PURPOSE
//  Registered, handshaked ALU-control stage. Decodes {aluop, funct} into an aluctl code and adds a
//  per-operation latency, so multi-cycle ops (muladdmod, double-xor) hold the ALU. Sits between the
//  ID/EX register and the ALU. It asserts alu_busy, and holds in_ready low, while a multi-cycle op runs.
// PARAMETERS
//  FUNCT_W  6  funct field width; only funct[3:0] is decoded, upper bits are ignored
//  CTL_W    4  aluctl width (>=4)
//  MAM_LAT  4  muladdmod (aluctl 10) cycles on the ALU, >=1
//  DXR_LAT  2  double-xor (aluctl 5) cycles on the ALU, >=1
//  CNT_W    4  hold-counter width; must satisfy 2**CNT_W > max(MAM_LAT,DXR_LAT)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        funct/aluop valid
//  in_ready   out  1        stage accepts this cycle
//  funct      in   FUNCT_W  R-type function field
//  aluop      in   2        0 add, 1 sub, 2 use funct, 3 add
//  out_valid  out  1        aluctl presented to ALU
//  out_ready  in   1        ALU takes aluctl this cycle
//  aluctl     out  CTL_W    ALU control code (registered)
//  illegal    out  1        aluop==2 with undecoded funct[3:0]; qualifies aluctl
//  alu_busy   out  1        multi-cycle op in progress after issue
//  hold_left  out  CNT_W    remaining hold cycles (0 when not HOLD)
// BEHAVIOUR
//  Reset: out_valid=0, aluctl=0, illegal=0, alu_busy=0, hold_left=0, state=IDLE. Reset wins over every
//   other event, including mid-HOLD and while out_valid is high without out_ready; the pending op is dropped.
//  Decode for aluop==2, keyed on funct[3:0]: 0->2 add, 2->6 sub, 3->5 dxor, 4->8 andor, 5->1 or,
//   6->13 xor, 7->12 nor, 8->10 muladdmod, 10->7 slt. Any other code -> aluctl 0 with illegal=1.
//   aluop 0 or 3 -> 2; aluop 1 -> 6; illegal=0 in all three cases.
//  lat = MAM_LAT for ctl 10, DXR_LAT for ctl 5, else 1. Codes are zero-extended to CTL_W.
//  Accept = in_valid & in_ready. Decode is registered: aluctl and out_valid update the cycle after accept.
//  FSM:
//   IDLE : in_ready=1, out_valid=0. On accept -> VALID.
//   VALID: out_valid=1. in_ready = out_ready & (lat==1).
//          out_ready & lat>1 -> HOLD, hold_left=lat-1.
//          out_ready & lat==1 & accept -> VALID with the new op (back-to-back, one op per cycle).
//          out_ready & lat==1 & no accept -> IDLE.
//          !out_ready -> stay in VALID; aluctl, illegal and out_valid are stable.
//   HOLD : out_valid=0, alu_busy=1, aluctl/illegal held stable. hold_left decrements each cycle.
//          in_ready = (hold_left==1). At hold_left==1: accept -> VALID, else -> IDLE.
//          hold_left is 0 on exit.
//  aluctl changes only on accept or reset. Input changes without accept have no effect.
//  Issue-to-issue spacing equals lat of the earlier op, so no ALU cycle is wasted.
// STRUCTURE
//  Shared include alu_ctl_defs.vh holds: ALUCTL_* codes (ADD=2, SUB=6, OR=1, XOR=13, NOR=12, SLT=7,
//   DXOR=5, ANDOR=8, MAM=10), FUNCT_* codes, and state encodings IDLE/VALID/HOLD.
//  One sub-module, alu_funct_decode, is purely combinational: funct, aluop -> ctl, illegal, lat.
//  Top level contains the FSM, output registers and hold counter.
// TESTING
//  1 reset, then aluop=2 funct=6'h20 (add), out_ready=1 -> next cycle out_valid=1, aluctl=2, illegal=0;
//    op then returns to IDLE.
//  2 back-to-back sub, or, slt (funct 2, 5, 10), in_valid and out_ready held high ->
//    aluctl 6, 1, 7 on consecutive cycles, in_ready stays 1.
//  3 muladdmod (funct 8), MAM_LAT=4, followed by an add -> one cycle out_valid with aluctl=10, then
//    3 cycles alu_busy with hold_left 3, 2, 1 and aluctl 10 held; add issues on the cycle after hold_left=1.
//  4 out_ready=0 for 5 cycles with xor pending -> aluctl=13 and out_valid stable, in_ready=0;
//    transfer completes on the first out_ready=1 cycle.
//  5 funct=6'h0B, aluop=2 -> aluctl=0, illegal=1. Then aluop=3 with the same funct -> aluctl=2, illegal=0.
//  6 reset asserted mid-HOLD (hold_left=2) -> next cycle all outputs are at their reset values;
//    a new op is accepted on the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_ctl_sequencer_pkg.sv
// Shared types, ALU control codes and funct keys for the ALU-control sequencer.
// funct_to_ctl maps funct[3:0] to an ALU control code and raises illegal for undecoded keys.
package alu_ctl_sequencer_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned KEY_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CODE_W-1:0] ALUCTL_OR    = 4'd1;
  localparam logic [CODE_W-1:0] ALUCTL_ADD   = 4'd2;
  localparam logic [CODE_W-1:0] ALUCTL_DXOR  = 4'd5;
  localparam logic [CODE_W-1:0] ALUCTL_SUB   = 4'd6;
  localparam logic [CODE_W-1:0] ALUCTL_SLT   = 4'd7;
  localparam logic [CODE_W-1:0] ALUCTL_ANDOR = 4'd8;
  localparam logic [CODE_W-1:0] ALUCTL_MAM   = 4'd10;
  localparam logic [CODE_W-1:0] ALUCTL_NOR   = 4'd12;
  localparam logic [CODE_W-1:0] ALUCTL_XOR   = 4'd13;

  localparam logic [KEY_W-1:0] FUNCT_ADD   = 4'h0;
  localparam logic [KEY_W-1:0] FUNCT_SUB   = 4'h2;
  localparam logic [KEY_W-1:0] FUNCT_DXOR  = 4'h3;
  localparam logic [KEY_W-1:0] FUNCT_ANDOR = 4'h4;
  localparam logic [KEY_W-1:0] FUNCT_OR    = 4'h5;
  localparam logic [KEY_W-1:0] FUNCT_XOR   = 4'h6;
  localparam logic [KEY_W-1:0] FUNCT_NOR   = 4'h7;
  localparam logic [KEY_W-1:0] FUNCT_MAM   = 4'h8;
  localparam logic [KEY_W-1:0] FUNCT_SLT   = 4'hA;

  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              illegal;
  } ctl_word_t;

  function automatic ctl_word_t funct_to_ctl(input logic [KEY_W-1:0] key);
    ctl_word_t w;
    w = '{code: '0, illegal: 1'b0};
    case (key)
      FUNCT_ADD:   w.code = ALUCTL_ADD;
      FUNCT_SUB:   w.code = ALUCTL_SUB;
      FUNCT_DXOR:  w.code = ALUCTL_DXOR;
      FUNCT_ANDOR: w.code = ALUCTL_ANDOR;
      FUNCT_OR:    w.code = ALUCTL_OR;
      FUNCT_XOR:   w.code = ALUCTL_XOR;
      FUNCT_NOR:   w.code = ALUCTL_NOR;
      FUNCT_MAM:   w.code = ALUCTL_MAM;
      FUNCT_SLT:   w.code = ALUCTL_SLT;
      default:     w.illegal = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/alu_ctl_sequencer_if.sv
// Handshake bus between the ID/EX side (master) and the ALU-control sequencer (slave).
// Groups the op input handshake and the registered ALU control output.
interface alu_ctl_sequencer_if #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTL_W   = 4,
  parameter int unsigned CNT_W   = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] funct;
  logic [1:0]         aluop;
  logic               out_valid;
  logic               out_ready;
  logic [CTL_W-1:0]   aluctl;
  logic               illegal;
  logic               alu_busy;
  logic [CNT_W-1:0]   hold_left;

  modport master (
    output in_valid, funct, aluop, out_ready,
    input  in_ready, out_valid, aluctl, illegal, alu_busy, hold_left
  );

  modport slave (
    input  in_valid, funct, aluop, out_ready,
    output in_ready, out_valid, aluctl, illegal, alu_busy, hold_left
  );
endinterface

// File: rtl/alu_ctl_sequencer_decode.sv
// Combinational decode of {aluop, funct} into an ALU control code, illegal flag and ALU latency.
// Only funct[3:0] participates; the upper funct bits are ignored.
module alu_funct_decode
  import alu_ctl_sequencer_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTL_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MAM_LAT = 4,
  parameter int unsigned DXR_LAT = 2
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [1:0]         aluop,
  output logic [CTL_W-1:0]   ctl,
  output logic               illegal,
  output logic [CNT_W-1:0]   lat
);

  ctl_word_t word;

  always_comb begin
    word = '{code: ALUCTL_ADD, illegal: 1'b0};
    case (aluop)
      ALUOP_SUB:   word.code = ALUCTL_SUB;
      ALUOP_FUNCT: word = funct_to_ctl(funct[KEY_W-1:0]);
      default:     word.code = ALUCTL_ADD;
    endcase
  end

  // Multi-cycle ops keep the ALU for their configured latency; everything else takes one cycle.
  always_comb begin
    lat = CNT_W'(1);
    if (word.code == ALUCTL_MAM)       lat = CNT_W'(MAM_LAT);
    else if (word.code == ALUCTL_DXOR) lat = CNT_W'(DXR_LAT);
  end

  assign ctl     = CTL_W'(word.code);
  assign illegal = word.illegal;

  if (FUNCT_W > KEY_W) begin : g_funct_hi
    logic funct_hi_unused;
    assign funct_hi_unused = ^funct[FUNCT_W-1:KEY_W];
  end

endmodule

// File: rtl/alu_ctl_sequencer.sv
// Registered, handshaked ALU-control stage: decodes ops and holds the ALU for multi-cycle ops.
// A pending or holding op is dropped on reset.
module alu_ctl_sequencer
  import alu_ctl_sequencer_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTL_W   = 4,
  parameter int unsigned MAM_LAT = 4,
  parameter int unsigned DXR_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_ctl_sequencer_if.slave   bus
);

  state_e           state;
  logic             out_valid;
  logic [CTL_W-1:0] aluctl;
  logic             illegal;
  logic             alu_busy;
  logic [CNT_W-1:0] hold_left;
  logic [CNT_W-1:0] lat_q;

  logic [CTL_W-1:0] dec_ctl;
  logic             dec_illegal;
  logic [CNT_W-1:0] dec_lat;
  logic             in_ready;
  logic             accept;

  alu_funct_decode #(
    .FUNCT_W (FUNCT_W),
    .CTL_W   (CTL_W),
    .CNT_W   (CNT_W),
    .MAM_LAT (MAM_LAT),
    .DXR_LAT (DXR_LAT)
  ) u_decode (
    .funct   (bus.funct),
    .aluop   (bus.aluop),
    .ctl     (dec_ctl),
    .illegal (dec_illegal),
    .lat     (dec_lat)
  );

  // A new op may enter only when the current one leaves the ALU this cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE:  in_ready = 1'b1;
      ST_VALID: in_ready = bus.out_ready && (lat_q == CNT_W'(1));
      ST_HOLD:  in_ready = (hold_left == CNT_W'(1));
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      aluctl    <= '0;
      illegal   <= 1'b0;
      alu_busy  <= 1'b0;
      hold_left <= '0;
      lat_q     <= CNT_W'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            aluctl    <= dec_ctl;
            illegal   <= dec_illegal;
            lat_q     <= dec_lat;
            out_valid <= 1'b1;
            state     <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (bus.out_ready) begin
            if (lat_q > CNT_W'(1)) begin
              out_valid <= 1'b0;
              alu_busy  <= 1'b1;
              hold_left <= CNT_W'(lat_q - CNT_W'(1));
              state     <= ST_HOLD;
            end else if (accept) begin
              aluctl    <= dec_ctl;
              illegal   <= dec_illegal;
              lat_q     <= dec_lat;
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (hold_left == CNT_W'(1)) begin
            hold_left <= '0;
            alu_busy  <= 1'b0;
            if (accept) begin
              aluctl    <= dec_ctl;
              illegal   <= dec_illegal;
              lat_q     <= dec_lat;
              out_valid <= 1'b1;
              state     <= ST_VALID;
            end else begin
              state     <= ST_IDLE;
            end
          end else begin
            hold_left <= CNT_W'(hold_left - CNT_W'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.aluctl    = aluctl;
  assign bus.illegal   = illegal;
  assign bus.alu_busy  = alu_busy;
  assign bus.hold_left = hold_left;

endmodule
